// File: rtl/stdout_tx_pkg.sv
// Shared types and constants for the stdout UART transmitter.
// The PARITY state is only reachable when STDOUT_TX_PARITY_EN is defined.
package stdout_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic TXD_IDLE       = 1'b1;
    localparam logic TXD_START      = 1'b0;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/stdout_fifo.sv
// Synchronous circular byte buffer with push/pop/full/empty/count.
// Shared by the stdout transmitter and a future stdin receiver.
module stdout_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; entries are only read after a push has written them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/stdout_uart_tx.sv
// stdout responder: queues bytes from the core and shifts them out as UART 8N1 on txd.
// Defining STDOUT_TX_PARITY_EN inserts an even-parity bit after the data bits (8E1).
module stdout_uart_tx
    import stdout_tx_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stdout_write_enable,
    input  logic [7:0]                    stdout_write_data,
    output logic                          stdout_stall,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          txd
);

    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;
    logic                      bit_done;

    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_head;

`ifdef STDOUT_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    stdout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stdout_write_enable),
        .push_data (stdout_write_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign stdout_stall = fifo_full;
    assign tx_busy      = (state_q != TX_IDLE);
    assign txd          = txd_q;
    assign bit_done     = (baud_q == LAST_BAUD);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
`ifdef STDOUT_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q != TX_IDLE) begin
            baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
`ifdef STDOUT_TX_PARITY_EN
                    parity_d = even_parity(fifo_head);
`endif
                    baud_d   = '0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == LAST_BIT) begin
`ifdef STDOUT_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end
                end
            end
`ifdef STDOUT_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_done) state_d = TX_STOP;
            end
`endif
            TX_STOP: begin
                // Chain straight into the next frame so there is no idle gap.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
`ifdef STDOUT_TX_PARITY_EN
                        parity_d = even_parity(fifo_head);
`endif
                        state_d  = TX_START;
                    end else begin
                        state_d  = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // txd is registered from next-state so the pin never glitches between bits.
    always_comb begin
        case (state_d)
            TX_START:  txd_d = TXD_START;
            TX_DATA:   txd_d = shift_d[0];
`ifdef STDOUT_TX_PARITY_EN
            TX_PARITY: txd_d = parity_d;
`endif
            default:   txd_d = TXD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= TXD_IDLE;
`ifdef STDOUT_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef STDOUT_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Scoreboard bench for stdout_uart_tx: a transaction-level model predicts accepted bytes and frame start times.
// Honours STDOUT_TX_PARITY_EN for the 11-bit frame and even-parity bit.
`timescale 1ns/1ps
module tb_stdout_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef STDOUT_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             we  = 1'b0;
    logic [7:0]       wd  = 8'h00;
    logic             stall;
    logic             busy;
    logic             txd;
    logic [CNT_W-1:0] cnt;

    stdout_uart_tx #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stdout_write_enable (we),
        .stdout_write_data   (wd),
        .stdout_stall        (stall),
        .fifo_count          (cnt),
        .tx_busy             (busy),
        .txd                 (txd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A byte is accepted when fewer than DEPTH are queued. The transmitter takes the head
    // whenever it is free; a frame taken at cycle p starts on the line at p+1 and the
    // transmitter is free again at p+FRAME_CYC (the last stop cycle).
    typedef struct {
        logic [7:0] data;
        longint     start;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_fifo[$];
    int         m_count  = 0;
    longint     last_pop = -1000000;
    longint     cyc      = 0;
    bit         mon_abort    = 1'b0;
    bit         mon_in_frame = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_fifo.delete();
            sb.delete();
            m_count  <= 0;
            last_pop <= -1000000;
        end else begin
            int   c;
            bit   take;
            bit   acc;
            exp_t e;
            c    = m_count;
            take = (c > 0) && (cyc >= last_pop + FRAME_CYC);
            acc  = we && (c < DEPTH);
            if (take) begin
                e.data  = m_fifo.pop_front();
                e.start = cyc + 1;
                sb.push_back(e);
                last_pop <= cyc;
                c = c - 1;
            end
            if (acc) begin
                m_fifo.push_back(wd);
                c = c + 1;
            end
            m_count <= c;
        end
        cyc <= cyc + 1;
    end

    function automatic bit model_busy();
        return (cyc > last_pop) && (cyc <= last_pop + FRAME_CYC);
    endfunction

    // Per-cycle status checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (!mon_abort) begin
            check("fifo_count", cnt, m_count);
            check("stall", stall, m_count == DEPTH);
            check("tx_busy", busy, model_busy());
            if (!model_busy()) check("txd_idle_high", txd, 1);
        end
    end

    // ---------------- line monitor ----------------
    initial begin
        logic [FRAME_BITS-1:0] bits;
        exp_t   e;
        longint st;
        forever begin
            @(negedge clk);
            if (!mon_abort && !rst && txd === 1'b0) begin
                st = cyc;
                mon_in_frame = 1'b1;
                for (int j = 0; j < FRAME_CYC; j++) begin
                    if (j > 0) @(negedge clk);
                    if (j % CPB == CPB / 2) bits[j / CPB] = txd;
                end
                mon_in_frame = 1'b0;
                if (!mon_abort) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("start_cycle", st, e.start);
                        check("start_bit", bits[0], 0);
                        check("data_byte", bits[8:1], e.data);
`ifdef STDOUT_TX_PARITY_EN
                        check("parity_bit", bits[9], $countones(e.data) % 2);
`endif
                        check("stop_bit", bits[FRAME_BITS-1], 1);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic en, input logic [7:0] d);
        we = en;
        wd = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        we = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_count == 0 && sb.size() == 0 && !mon_in_frame && !model_busy()) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("drain_within_budget", done, 1);
        repeat (3) drive(1'b0, 8'h00);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("reset_txd", txd, 1);
        check("reset_count", cnt, 0);
        check("reset_busy", busy, 0);
        check("reset_stall", stall, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) drive(1'b0, 8'h00);

        // Single byte.
        drive(1'b1, 8'h41);
        drain();

        // Back-to-back pair.
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        drain();

        // Fill past depth: six consecutive writes, the last is dropped.
        for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom));
        drain();

        // Write held through several frames: exercises full + pop in the same cycle.
        for (int i = 0; i < 3 * FRAME_CYC; i++) drive(1'b1, 8'($urandom));
        drain();

        // Parity-sensitive bytes.
        drive(1'b1, 8'h07);
        drive(1'b1, 8'h03);
        drain();

        // Random traffic.
        for (int i = 0; i < 500; i++) drive(($urandom % 3) == 0, 8'($urandom));
        drain();

        // Reset mid-frame with a full queue.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h00);
        we = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("pre_reset_txd_low", txd, 0);
        check("pre_reset_stall", stall, 1);
        mon_abort = 1'b1;
        rst = 1'b1;
        #1;
        check("midframe_reset_txd", txd, 1);
        check("midframe_reset_count", cnt, 0);
        check("midframe_reset_busy", busy, 0);
        check("midframe_reset_stall", stall, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_txd", txd, 1);
        check("post_reset_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
